multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
Multicycle sequencer for the LEGv8 core. It drives the fetch, decode, execute, memory and writeback steps around instr_parse, which supplies the 11-bit opcode from the instruction register. The block decodes the opcode class, issues one-cycle datapath strobes per state, and handshakes with instruction and data memory. It counts retired instructions and traps on illegal opcodes or memory timeouts.

Parameters:
CNT_W, 16, width of retired-instruction counter
TIMEOUT, 15, max cycles waiting on imem_ready/dmem_ready before trap (1..255)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
opcode  in  11  opcode field from instr_parse (valid from DECODE onward)
zero  in  1  ALU zero flag, sampled in EXEC only
imem_ready  in  1  instruction memory has data this cycle
dmem_ready  in  1  data memory access completes this cycle
imem_req  out  1  instruction fetch request
ir_write  out  1  load instruction register
pc_write  out  1  update PC
pc_src  out  1  0 = PC+4, 1 = branch target
reg2_loc  out  1  1 = second read register from Rt field (STUR, CBZ)
alu_src  out  1  1 = ALU B operand is sign-extended address
alu_op  out  2  00 add, 01 pass B (CBZ), 10 R-type by opcode
dmem_read  out  1  data memory read strobe
dmem_write  out  1  data memory write strobe
mem_to_reg  out  1  writeback selects memory data
reg_write  out  1  register file write enable
state  out  3  current state, for debug
instr_count  out  CNT_W  retired instruction count
trap  out  1  sticky; FSM halted
trap_cause  out  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7. Encodings 5 and 6 are unused and go to TRAP with cause 01.
- Reset: state=FETCH; class register=0; wait counter=0; instr_count=0; trap=0; trap_cause=00. All strobes are combinational from state and class, so after reset only imem_req=1 and every other output is 0.
- Opcode classes, latched in DECODE:
  - LDUR: 0x7C2
  - STUR: 0x7C0
  - R-type: ADD 0x458, SUB 0x658, AND 0x450, ORR 0x550
  - CBZ: opcode[10:3]=8'hB4
  - B: opcode[10:5]=6'b000101
  - Anything else: illegal; DECODE goes to TRAP with cause 01.
- FETCH:
  - imem_req=1.
  - When imem_ready=1: ir_write=1, pc_write=1, pc_src=0, next state DECODE.
  - Otherwise stay in FETCH and increment the wait counter. When the counter reaches TIMEOUT with imem_ready still 0, go to TRAP with cause 10.
- DECODE:
  - reg2_loc reflects the opcode presented this cycle.
  - No strobes.
  - Next state EXEC (or TRAP if illegal).
- EXEC:
  - alu_src, alu_op and reg2_loc come from the latched class.
  - B: pc_write=1, pc_src=1, retire, next FETCH.
  - CBZ: pc_write=zero, pc_src=1, retire, next FETCH.
  - LDUR/STUR: next MEM.
  - R-type: next WB.
- MEM:
  - dmem_read=1 for LDUR, dmem_write=1 for STUR. Both hold until dmem_ready.
  - On dmem_ready=1: LDUR goes to WB; STUR retires and goes to FETCH.
  - Timeout at TIMEOUT cycles goes to TRAP with cause 11. The wait counter clears on every state change.
- WB: reg_write=1 for exactly one cycle, mem_to_reg=1 for LDUR only, retire, next FETCH.
- TRAP:
  - All strobes 0, imem_req=0.
  - trap=1, trap_cause held.
  - Leaves only on reset.
- Retire: instr_count increments by 1 in the retiring cycle and wraps modulo 2^CNT_W. Illegal or trapped instructions do not retire.
- Latency with ready=1 throughout: R-type 4 cycles, LDUR 5, STUR 4, CBZ 3, B 3.
- Ready inputs are ignored outside their own state. reg_write and dmem_write are never asserted in the same cycle.
- Reset asserted in any state, including mid-MEM with dmem_write high, returns to FETCH on the next edge. Strobes drop that same edge and nothing retires.

Test Plan:
1. Reset, imem_ready=1, IR=F84F02C9 (opcode 1986, LDUR), dmem_ready=1 -> states 0,1,2,3,4,0. dmem_read=1 in MEM, reg_write=1 and mem_to_reg=1 in WB only, alu_src=1, alu_op=00, instr_count=1 after 5 cycles.
2. Opcode 1112 (ADD X10,X21,X9) followed by opcode 1984 (STUR X10,[X23,#64]) with dmem_ready held low 3 cycles -> ADD: 4 cycles, alu_op=10, reg_write in WB. STUR: dmem_write high for 4 MEM cycles, reg2_loc=1, never reg_write. instr_count=2.
3. CBZ (opcode 0x5A0) with zero=1, then again with zero=0 -> pc_write=1 and pc_src=1 in EXEC for the first, pc_write=0 for the second. Each takes 3 cycles.
4. Opcode 0x000 -> TRAP after DECODE with trap=1, cause 01, all strobes 0 for 20 cycles, count unchanged. Reset clears trap and cause and returns to FETCH.
5. imem_ready=0 held for TIMEOUT=15 cycles -> TRAP with cause 10. Separately, dmem_ready=0 on LDUR -> cause 11.
6. CNT_W=4 with 16 B instructions (opcode 0x0A0) -> instr_count wraps 15 to 0. Reset asserted mid-MEM of a STUR -> dmem_write low next cycle, state=0, count=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the LEGv8 core.
// Strobes are decoded from the current state and the latched opcode class.
module multicycle_control #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      opcode,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg2_loc,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             dmem_read,
    output logic             dmem_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count,
    output logic             trap,
    output logic [1:0]       trap_cause
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_NONE  = 3'd0,
        C_LDUR  = 3'd1,
        C_STUR  = 3'd2,
        C_RTYPE = 3'd3,
        C_CBZ   = 3'd4,
        C_B     = 3'd5
    } class_t;

    localparam logic [7:0]       WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_IMEM    = 2'b10;
    localparam logic [1:0] CAUSE_DMEM    = 2'b11;

    state_t     cur_state;
    class_t     cls;
    class_t     dec_class;
    logic [7:0] wait_cnt;

    // C_NONE doubles as the illegal-opcode result.
    function automatic class_t decode_op(input logic [10:0] op);
        class_t c;
        c = C_NONE;
        if (op == 11'h7C2)
            c = C_LDUR;
        else if (op == 11'h7C0)
            c = C_STUR;
        else if (op == 11'h458 || op == 11'h658 || op == 11'h450 || op == 11'h550)
            c = C_RTYPE;
        else if (op[10:3] == 8'hB4)
            c = C_CBZ;
        else if (op[10:5] == 6'b000101)
            c = C_B;
        return c;
    endfunction

    always_comb begin
        dec_class = decode_op(opcode);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state   <= S_FETCH;
            cls         <= C_NONE;
            wait_cnt    <= '0;
            instr_count <= '0;
            trap        <= 1'b0;
            trap_cause  <= 2'b00;
        end else begin
            case (cur_state)
                S_FETCH: begin
                    if (imem_ready) begin
                        cur_state <= S_DECODE;
                        wait_cnt  <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        cur_state  <= S_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= CAUSE_IMEM;
                        wait_cnt   <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                S_DECODE: begin
                    if (dec_class == C_NONE) begin
                        cur_state  <= S_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= CAUSE_ILLEGAL;
                    end else begin
                        cls       <= dec_class;
                        cur_state <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    case (cls)
                        C_B, C_CBZ: begin
                            instr_count <= instr_count + CNT_ONE;
                            cur_state   <= S_FETCH;
                        end
                        C_LDUR, C_STUR: cur_state <= S_MEM;
                        C_RTYPE:        cur_state <= S_WB;
                        default: begin
                            cur_state  <= S_TRAP;
                            trap       <= 1'b1;
                            trap_cause <= CAUSE_ILLEGAL;
                        end
                    endcase
                end

                S_MEM: begin
                    if (dmem_ready) begin
                        wait_cnt <= '0;
                        if (cls == C_LDUR) begin
                            cur_state <= S_WB;
                        end else begin
                            instr_count <= instr_count + CNT_ONE;
                            cur_state   <= S_FETCH;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        cur_state  <= S_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= CAUSE_DMEM;
                        wait_cnt   <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                S_WB: begin
                    instr_count <= instr_count + CNT_ONE;
                    cur_state   <= S_FETCH;
                end

                S_TRAP: cur_state <= S_TRAP;

                // Encodings 5 and 6 are unreachable; treat them as corruption.
                default: begin
                    cur_state  <= S_TRAP;
                    trap       <= 1'b1;
                    trap_cause <= CAUSE_ILLEGAL;
                end
            endcase
        end
    end

    always_comb begin
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg2_loc   = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        case (cur_state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            // The class register is not loaded yet, so decode the live opcode.
            S_DECODE: reg2_loc = (dec_class == C_STUR) || (dec_class == C_CBZ);
            S_EXEC: begin
                reg2_loc = (cls == C_STUR) || (cls == C_CBZ);
                alu_src  = (cls == C_LDUR) || (cls == C_STUR);
                if (cls == C_RTYPE)
                    alu_op = 2'b10;
                else if (cls == C_CBZ)
                    alu_op = 2'b01;
                if (cls == C_B) begin
                    pc_write = 1'b1;
                    pc_src   = 1'b1;
                end else if (cls == C_CBZ) begin
                    pc_write = zero;
                    pc_src   = 1'b1;
                end
            end
            S_MEM: begin
                dmem_read  = (cls == C_LDUR);
                dmem_write = (cls == C_STUR);
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls == C_LDUR);
            end
            default: ;
        endcase
    end

    assign state = cur_state;

endmodule
